char_glyph_writer: RTL and testbench

Write-side companion to the VGA ASCII character path. It accepts a glyph-slot command followed by eight row bytes over valid/ready handshakes and packs them into one 64-bit glyph. It then issues a single-cycle write into the mini character ROM/RAM through that memory's `w_en`/`addr`/`in_data` port, so the glyph can be updated at runtime. The packed bit order is the one the pixel readout uses: bit `63 - (8*row + col)`.

---
 rtl/char_glyph_writer.sv | 90 +++++++++
 tb/tb_char_glyph_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_glyph_writer.sv
// Glyph loader for the VGA character memory: takes a slot command plus eight row
// bytes over valid/ready, packs them MSB-first and issues a one-cycle memory write.
module char_glyph_writer #(
  parameter int ADDR_W = 4
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [7:0]        row_data,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        row_cnt_q;
  logic [63:0]       shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [63:0]       wr_data_q;
  logic [63:0]       shift_d;

  // Row 0 enters first and ends up in the top byte after eight shifts.
  assign shift_d = {shift_q[55:0], row_data};

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            shift_q   <= '0;
            row_cnt_q <= '0;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          // Abort takes priority over a byte offered in the same cycle.
          if (abort) begin
            state_q <= IDLE;
          end else if (row_valid) begin
            shift_q   <= shift_d;
            row_cnt_q <= row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) begin
              wr_addr_q <= addr_q;
              wr_data_q <= shift_d;
              state_q   <= WRITE;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write port registers only change when entering WRITE, so they hold between writes.
  assign cmd_ready = (state_q == IDLE);
  assign row_ready = (state_q == LOAD);
  assign wr_en     = (state_q == WRITE);
  assign done      = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_char_glyph_writer.sv
// Scoreboard bench for char_glyph_writer: expected writes are queued as glyphs are
// driven and compared when the write strobe appears.
module tb_char_glyph_writer;

  logic        vga_clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_addr;
  logic        row_valid;
  logic        row_ready;
  logic [7:0]  row_data;
  logic        abort;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;

  char_glyph_writer #(.ADDR_W(4)) dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   wr_cyc = 0;
  int   rows_acc = 0;

  localparam logic [63:0] GLYPH_S = 64'h3C42407C0202423C;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Handshake bookkeeping, sampled before the DUT's registers update on this edge.
  always @(posedge vga_clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cyc  = cyc;
      rows_acc = 0;
    end else if (row_valid && row_ready) begin
      rows_acc++;
    end
    cyc++;
  end

  always @(negedge vga_clk) begin
    if (rst_n && (wr_en || done)) begin
      check("done_vs_wr_en", 64'(done), 64'(wr_en));
      if (sb.size() == 0) begin
        check("unexpected_wr_en", 64'(wr_en), 64'd0);
      end else if (wr_en) begin
        e = sb.pop_front();
        wr_cyc = cyc;
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", wr_data, e.data);
        check("rows_accepted", 64'(rows_acc), 64'd8);
        if (e.lat >= 0) check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic send_cmd(input logic [3:0] a);
    int n;
    n = 0;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= 100) check("cmd_timeout", 64'(cmd_ready), 64'd1);
    @(negedge vga_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] d);
    int n;
    n = 0;
    row_data  = d;
    row_valid = 1'b1;
    while (!row_ready && n < 100) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= 100) check("row_timeout", 64'(row_ready), 64'd1);
    @(negedge vga_clk);
    row_valid = 1'b0;
  endtask

  task automatic send_rows(input logic [63:0] g, input int maxgap, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge vga_clk);
      send_row(g[63-8*r -: 8]);
    end
  endtask

  task automatic glyph(input logic [3:0] a, input logic [63:0] g, input int maxgap, input int lat);
    exp_t x;
    x.addr = a;
    x.data = g;
    x.lat  = lat;
    sb.push_back(x);
    send_cmd(a);
    send_rows(g, maxgap, 8);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(busy), 64'd0);
    @(negedge vga_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_row_ready"}, 64'(row_ready), 64'd0);
    check({tag, "_wr_en"},     64'(wr_en),     64'd0);
    check({tag, "_wr_addr"},   64'(wr_addr),   64'd0);
    check({tag, "_wr_data"},   wr_data,        64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    exp_t x;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0;
    row_valid = 1'b0; row_data = '0; abort = 1'b0;
    repeat (3) @(negedge vga_clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge vga_clk);

    // Basic write, back-to-back: write cycle is the 10th counting the command cycle.
    glyph(4'h5, GLYPH_S, 0, 9);
    wait_idle();
    check("basic_busy_after", 64'(busy), 64'd0);
    repeat (3) @(negedge vga_clk);
    check("hold_wr_addr", 64'(wr_addr), 64'h5);
    check("hold_wr_data", wr_data, GLYPH_S);

    // Bit order: row 2 column 3 lands at bit 63-(8*2+3).
    glyph(4'h2, 64'h0000100000000000, 0, 9);
    wait_idle();
    check("bit_r2_c3", 64'(wr_data[63-(8*2+3)]), 64'd1);

    // Gapped rows.
    glyph(4'h7, GLYPH_S, 5, -1);
    wait_idle();

    // Abort together with a 6th row offer.
    send_cmd(4'h3);
    send_rows(64'hFFFFFFFFFFFFFFFF, 0, 5);
    row_data = 8'hAA; row_valid = 1'b1; abort = 1'b1;
    @(negedge vga_clk);
    row_valid = 1'b0; abort = 1'b0;
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    glyph(4'hF, 64'h0123456789ABCDEF, 0, 9);
    wait_idle();

    // Stray row bytes in IDLE are not consumed.
    row_data = 8'hFF; row_valid = 1'b1;
    repeat (3) begin
      @(negedge vga_clk);
      check("stray_row_ready", 64'(row_ready), 64'd0);
      check("stray_busy", 64'(busy), 64'd0);
    end
    row_valid = 1'b0;
    glyph(4'h1, 64'h8040201008040201, 0, 9);
    wait_idle();

    // Command offered during LOAD waits for the first IDLE cycle after WRITE.
    x.addr = 4'h6; x.data = 64'h1122334455667788; x.lat = 9;
    sb.push_back(x);
    fork
      begin
        send_cmd(4'h6);
        send_rows(64'h1122334455667788, 0, 8);
      end
      begin
        repeat (3) @(negedge vga_clk);
        check("load_cmd_ready", 64'(cmd_ready), 64'd0);
        send_cmd(4'h9);
      end
    join
    check("pending_accept_cycle", 64'(acc_cyc), 64'(wr_cyc + 1));
    x.addr = 4'h9; x.data = 64'hA5A5A5A55A5A5A5A; x.lat = 9;
    sb.push_back(x);
    send_rows(64'hA5A5A5A55A5A5A5A, 0, 8);
    wait_idle();

    // Asynchronous reset between edges after three rows.
    send_cmd(4'h4);
    send_rows(64'hDEADBEEFCAFEF00D, 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge vga_clk);
    rst_n = 1'b1;
    @(negedge vga_clk);
    glyph(4'h4, 64'h0F0F0F0FF0F0F0F0, 0, 9);
    wait_idle();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
